hms_clock_ctrl: RTL and testbench
=================================

Name: hms_clock_ctrl

Overview:
- Time-keeping controller for the 24-hour display clock.
- A prescaler divides clk down to a 1 Hz tick. The block sequences the cascaded modulo-60 seconds, modulo-60 minutes and modulo-24 hours counters, generating each carry enable.
- A small mode FSM lets the user set hours and minutes with two pre-debounced button pulses.
- Outputs feed the display decoder and the alarm compare logic.

Parameters:
- TICK_DIV, 50000000, clk cycles per second tick. Legal range is 2 or more. Prescaler width is clog2(TICK_DIV).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- btn_mode  in  1  single-cycle pulse, debounced and synchronous to clk; advances the mode FSM
- btn_inc  in  1  single-cycle pulse, debounced and synchronous to clk; increments the selected field in set modes
- sec  out  6  seconds, 0..59
- min  out  6  minutes, 0..59
- hour  out  5  hours, 0..23
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN; value 3 is never driven
- sec_tick  out  1  one-cycle pulse when sec advances in RUN
- min_tick  out  1  one-cycle pulse when sec wraps 59->0 and min advances
- day_tick  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset:
  - rstn is an asynchronous, active-low reset; clk is the clock.
  - While rstn=0: sec=min=hour=0, mode=RUN, prescaler=0, all tick outputs 0.
  - Reset asserted mid-operation (any mode) forces this state immediately.
- All outputs are registered. Ticks are high in the same cycle the updated count is visible.
- Prescaler, RUN mode only:
  - Counts 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1, it returns to 0 and a second event occurs.
  - First sec=1 appears exactly TICK_DIV rising edges after rstn deasserts.
- Second event:
  - sec_tick=1 and sec increments.
  - If sec was 59: sec=0, min_tick=1, min increments.
  - If min was also 59: min=0, hour increments.
  - If hour was also 23: hour=0, day_tick=1.
  - Only counts 0..59 and 0..23 ever occur; no out-of-range value is ever driven.
- FSM transitions on btn_mode: RUN -> SET_HOUR -> SET_MIN -> RUN.
- SET_HOUR and SET_MIN:
  - Prescaler held at 0; no second events; all ticks 0.
  - btn_inc increments the selected field with wrap: hour 23->0, min 59->0.
  - A set-mode wrap produces no carry into other fields and no tick.
- Leaving SET_MIN for RUN:
  - sec is cleared to 0 and the prescaler restarts from 0.
  - Next sec_tick occurs TICK_DIV cycles later.
- Entering SET_HOUR from RUN: sec retains its value, which stays frozen.
- btn_inc in RUN is ignored.
- btn_mode and btn_inc in the same cycle: the mode transition is taken and the increment is discarded.
- btn_mode on the same edge as a second event in RUN: the mode change wins. Time is not advanced, ticks stay 0 and the prescaler goes to 0.
- Ticks are never asserted for more than one consecutive cycle. In RUN, consecutive sec_ticks are exactly TICK_DIV cycles apart.

Test Plan (TICK_DIV=4):
- Apply reset, release, run 4 cycles -> all outputs 0 before; sec=1 and sec_tick=1 on cycle 4; sec_tick=0 on cycle 5.
- Run 240 cycles from reset -> sec=0, min=1 with a single min_tick on cycle 240; exactly 60 sec_ticks seen.
- Set the clock to 23:59, then return to RUN:
  - Stimulus: btn_mode, 23x btn_inc, btn_mode, 59x btn_inc, btn_mode.
  - Expected at RUN entry: hour=23, min=59, sec=0.
  - After 240 cycles: 00:00:00 with day_tick, min_tick and sec_tick all high in that one cycle.
- Wrap in set mode: in SET_HOUR from hour=0, apply 24 btn_inc -> hour=0, min unchanged, no ticks. In SET_MIN apply 60 btn_inc -> min=0.
- Simultaneous buttons: in SET_HOUR, pulse btn_mode and btn_inc together -> mode=SET_MIN and hour unchanged.
- Mode change on a tick edge: in RUN with prescaler=3, pulse btn_mode -> mode=SET_HOUR, sec unchanged, sec_tick=0.
- Reset mid-set: assert rstn=0 asynchronously in SET_MIN with hour=5, min=7 -> immediately mode=RUN and time 00:00:00.

Source files
------------

// File: rtl/hms_clock_ctrl.sv
// 24-hour time-keeping controller: 1 Hz prescaler, cascaded sec/min/hour counters
// and a RUN / SET_HOUR / SET_MIN mode FSM driven by pre-debounced button pulses.
module hms_clock_ctrl #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_tick
);

    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSetHour = 2'd1,
        StSetMin  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hour_q, hour_d;
    logic            sec_tick_q, sec_tick_d;
    logic            min_tick_q, min_tick_d;
    logic            day_tick_q, day_tick_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StRun;
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            min_tick_q <= min_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = 1'b0;
        min_tick_d = 1'b0;
        day_tick_d = 1'b0;

        unique case (state_q)
            StRun: begin
                // A mode press on the terminal prescaler count swallows that second.
                if (btn_mode) begin
                    state_d = StSetHour;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d    = '0;
                    sec_tick_d = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d      = '0;
                        min_tick_d = 1'b1;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            if (hour_q == 5'd23) begin
                                hour_d     = '0;
                                day_tick_d = 1'b1;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StSetHour: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = StSetMin;
                end else if (btn_inc) begin
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end
            end
            StSetMin: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = StRun;
                    sec_d   = '0;
                end else if (btn_inc) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                state_d = StRun;
                presc_d = '0;
            end
        endcase
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hour     = hour_q;
    assign mode     = state_q;
    assign sec_tick = sec_tick_q;
    assign min_tick = min_tick_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Self-checking bench for hms_clock_ctrl: hand-derived vector table, directed corner
// sequences and random button traffic against a seconds-of-day reference model.
module tb_hms_clock_ctrl;

    localparam int unsigned TD = 4;

    logic       clk;
    logic       rstn;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       sec_tick;
    logic       min_tick;
    logic       day_tick;

    hms_clock_ctrl #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .mode     (mode),
        .sec_tick (sec_tick),
        .min_tick (min_tick),
        .day_tick (day_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time of day in seconds, mode and cycles since last second boundary.
    int m_tod;
    int m_mode;
    int m_phase;
    int m_st, m_mt, m_dt;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_mode = 0; m_phase = 0;
        m_st = 0; m_mt = 0; m_dt = 0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        int h, m;
        m_st = 0; m_mt = 0; m_dt = 0;
        case (m_mode)
            0: begin
                if (bm) begin
                    m_mode = 1; m_phase = 0;
                end else if (m_phase == TD - 1) begin
                    m_phase = 0;
                    m_tod = (m_tod + 1) % 86400;
                    m_st = 1;
                    m_mt = (m_tod % 60 == 0) ? 1 : 0;
                    m_dt = (m_tod == 0) ? 1 : 0;
                end else begin
                    m_phase++;
                end
            end
            1: begin
                if (bm) m_mode = 2;
                else if (bi) begin
                    h = (m_tod / 3600 + 1) % 24;
                    m_tod = h * 3600 + m_tod % 3600;
                end
            end
            default: begin
                if (bm) begin
                    m_mode = 0; m_phase = 0;
                    m_tod = m_tod - m_tod % 60;
                end else if (bi) begin
                    m = ((m_tod / 60) % 60 + 1) % 60;
                    m_tod = (m_tod / 3600) * 3600 + m * 60 + m_tod % 60;
                end
            end
        endcase
    endtask

    task automatic check_model(input string name);
        checks++;
        if (sec != 6'(m_tod % 60) || min != 6'((m_tod / 60) % 60) || hour != 5'(m_tod / 3600)
            || mode != 2'(m_mode) || sec_tick != 1'(m_st) || min_tick != 1'(m_mt)
            || day_tick != 1'(m_dt)) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d ticks=%b%b%b expected %0d:%0d:%0d mode=%0d ticks=%0d%0d%0d at %0t",
                     name, hour, min, sec, mode, sec_tick, min_tick, day_tick,
                     m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode, m_st, m_mt, m_dt,
                     $time);
        end
    endtask

    // Inputs driven after a falling edge, model advanced on the rising edge, outputs
    // compared on the following falling edge.
    task automatic cycle(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        model_step(bm, bi);
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        check_model("model");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        bit bm;
        bit bi;
        int n;
        int mode;
        int hour;
        int min;
        int sec;
        int st;
    } vec_t;

    vec_t tbl[10];
    int   nst, nmt;

    initial begin
        tbl[0] = '{0, 0, 3, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 0, 0, 1, 1};
        tbl[2] = '{0, 0, 1, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 1, 1, 0, 0, 0, 1, 0};
        tbl[4] = '{1, 0, 1, 1, 0, 0, 1, 0};
        tbl[5] = '{0, 1, 5, 1, 5, 0, 1, 0};
        tbl[6] = '{1, 1, 1, 2, 5, 0, 1, 0};
        tbl[7] = '{0, 1, 7, 2, 5, 7, 1, 0};
        tbl[8] = '{1, 0, 1, 0, 5, 7, 0, 0};
        tbl[9] = '{0, 0, 4, 0, 5, 7, 1, 1};

        rstn = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        model_reset();
        #12;
        check("reset_sec", int'(sec), 0);
        check("reset_mode", int'(mode), 0);
        check("reset_ticks", int'({sec_tick, min_tick, day_tick}), 0);
        do_reset();

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].bm, tbl[i].bi);
            check($sformatf("vec%0d_mode", i), int'(mode), tbl[i].mode);
            check($sformatf("vec%0d_hour", i), int'(hour), tbl[i].hour);
            check($sformatf("vec%0d_min", i), int'(min), tbl[i].min);
            check($sformatf("vec%0d_sec", i), int'(sec), tbl[i].sec);
            check($sformatf("vec%0d_sec_tick", i), int'(sec_tick), tbl[i].st);
        end

        // One minute from reset.
        do_reset();
        nst = 0; nmt = 0;
        for (int c = 1; c <= 240; c++) begin
            cycle(0, 0);
            nst += int'(sec_tick);
            nmt += int'(min_tick);
        end
        check("minute_min_tick", int'(min_tick), 1);
        check("minute_min", int'(min), 1);
        check("minute_sec", int'(sec), 0);
        check("minute_sec_ticks", nst, 60);
        check("minute_min_ticks", nmt, 1);

        // Set 23:59 and roll over the day.
        do_reset();
        cycle(1, 0);
        repeat (23) cycle(0, 1);
        cycle(1, 0);
        repeat (59) cycle(0, 1);
        cycle(1, 0);
        check("set_hour", int'(hour), 23);
        check("set_min", int'(min), 59);
        check("set_sec", int'(sec), 0);
        check("set_mode", int'(mode), 0);
        repeat (240) cycle(0, 0);
        check("day_time", int'({hour, min, sec}), 0);
        check("day_ticks", int'({sec_tick, min_tick, day_tick}), 7);

        // Wrap in set modes.
        cycle(1, 0);
        nst = 0;
        for (int k = 0; k < 24; k++) begin
            cycle(0, 1);
            nst += int'(sec_tick) + int'(min_tick) + int'(day_tick);
        end
        check("wrap_hour", int'(hour), 0);
        check("wrap_hour_min", int'(min), 0);
        check("wrap_hour_ticks", nst, 0);
        cycle(1, 0);
        repeat (60) cycle(0, 1);
        check("wrap_min", int'(min), 0);
        check("wrap_min_hour", int'(hour), 0);
        cycle(1, 0);

        // Mode press on the terminal prescaler count.
        repeat (4) cycle(0, 0);
        repeat (3) cycle(0, 0);
        cycle(1, 0);
        check("edge_mode", int'(mode), 1);
        check("edge_sec", int'(sec), 1);
        check("edge_sec_tick", int'(sec_tick), 0);

        // Asynchronous reset while setting minutes.
        repeat (5) cycle(0, 1);
        cycle(1, 0);
        repeat (7) cycle(0, 1);
        check("preset_hm", int'({hour, min}), (5 << 6) | 7);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("async_mode", int'(mode), 0);
        check("async_time", int'({hour, min, sec}), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Random button traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
